// File: rtl/multiplicador_secuencial_if.sv
// Handshake/operand bus for the sequential multiply-accumulate unit.
// The master drives the request and the operands; the slave returns the result and status.
interface multiplicador_secuencial_if #(
  parameter int tamanyo = 32
);
  logic                   START;
  logic [tamanyo-1:0]     Coc;
  logic [tamanyo-1:0]     Den;
  logic [tamanyo-1:0]     Res;
  logic [2*tamanyo-1:0]   Num;
  logic                   Done;
  logic                   Busy;

  modport master (output START, Coc, Den, Res, input Num, Done, Busy);
  modport slave  (input START, Coc, Den, Res, output Num, Done, Busy);
endinterface

// File: rtl/multiplicador_secuencial.sv
// Sequential shift-add multiplier that rebuilds a dividend: Num = Coc*Den + Res.
// The operands are converted to magnitudes, multiplied one bit per cycle, and the
// sign and remainder are applied in a final cycle.
// Optional macro MULT_EARLY_DONE_EN: leave CALC as soon as the remaining multiplier
// bits are all zero. Without it, latency is fixed at tamanyo+1 cycles.
module multiplicador_secuencial #(
  parameter int tamanyo = 32
) (
  input logic                        CLK,
  input logic                        RSTa,
  multiplicador_secuencial_if.slave  bus
);
  localparam int CW = $clog2(tamanyo) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                 state_q, state_d;
  logic [tamanyo-1:0]     mult_q, mult_d;   // |Coc|, shifted right each step
  logic [tamanyo-1:0]     den_q, den_d;     // |Den|
  logic [tamanyo-1:0]     res_q, res_d;
  logic                   sign_q, sign_d;
  logic [2*tamanyo-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*tamanyo-1:0]   num_q, num_d;
  logic                   done_q, done_d;

  // Next-state and datapath updates; every target holds its value unless a state changes it.
  always_comb begin
    state_d = state_q;
    mult_d  = mult_q;
    den_d   = den_q;
    res_d   = res_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = CALC;
          // The magnitude of the most negative value wraps to the correct unsigned 2^(tamanyo-1).
          mult_d  = bus.Coc[tamanyo-1] ? (~bus.Coc + 1'b1) : bus.Coc;
          den_d   = bus.Den[tamanyo-1] ? (~bus.Den + 1'b1) : bus.Den;
          sign_d  = bus.Coc[tamanyo-1] ^ bus.Den[tamanyo-1];
          res_d   = bus.Res;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        if (mult_q[0])
          acc_d = acc_q + ({{tamanyo{1'b0}}, den_q} << cnt_q);
        mult_d = mult_q >> 1;
        cnt_d  = cnt_q + 1'b1;
`ifdef MULT_EARLY_DONE_EN
        if ((mult_q >> 1) == '0 || cnt_q == CW'(tamanyo - 1))
          state_d = FIN;
`else
        if (cnt_q == CW'(tamanyo - 1))
          state_d = FIN;
`endif
      end
      FIN: begin
        num_d   = (sign_q ? (~acc_q + 1'b1) : acc_q) + {{tamanyo{res_q[tamanyo-1]}}, res_q};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over any pending request.
  always_ff @(posedge CLK) begin
    if (RSTa) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers; reset discards any in-flight operation.
  always_ff @(posedge CLK) begin
    if (RSTa) begin
      mult_q <= '0;
      den_q  <= '0;
      res_q  <= '0;
      sign_q <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      num_q  <= '0;
      done_q <= 1'b0;
    end else begin
      mult_q <= mult_d;
      den_q  <= den_d;
      res_q  <= res_d;
      sign_q <= sign_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      done_q <= done_d;
    end
  end

  assign bus.Num  = num_q;
  assign bus.Done = done_q;
  assign bus.Busy = (state_q != IDLE);
endmodule
